// File: rtl/uart_rx_if.sv
// Receive-side word bus from uart_rx to the RX FIFO.
// The master drives the word, its write strobe and the framing status.
interface uart_rx_if #(
  parameter int unsigned DBIT = 8
);
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick;
  logic            frame_err;

  modport master (
    output rx_dout,
    output rx_done_tick,
    output frame_err
  );

  modport slave (
    input rx_dout,
    input rx_done_tick,
    input frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop decoding, LSB first, with a
// one-clk write strobe and framing-error flag toward the RX FIFO.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      s_tick,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHi
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_s;

  logic s_mid, s_bit_end, s_stop_end, n_last;

  assign s_mid      = (s_q == SW'(7));
  assign s_bit_end  = (s_q == SW'(15));
  assign s_stop_end = (s_q == SW'(SB_TICK - 1));
  assign n_last     = (n_q == NW'(DBIT - 1));

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (s_tick && s_mid) state_d = rx_s ? StIdle : StData;
      end
      StData: begin
        if (s_tick && s_bit_end && n_last) state_d = StStop;
      end
      StStop: begin
        if (s_tick && s_stop_end) state_d = rx_s ? StIdle : StWaitHi;
      end
      StWaitHi: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_d    = s_q;
    n_d    = n_q;
    b_d    = b_q;
    dout_d = dout_q;
    ferr_d = ferr_q;
    done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s) s_d = '0;
      end
      StStart: begin
        if (s_tick) begin
          if (s_mid) begin
            if (!rx_s) begin
              s_d = '0;
              n_d = '0;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_bit_end) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (!n_last) n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_stop_end) begin
            dout_d = b_q;
            ferr_d = ~rx_s;
            done_d = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.rx_dout      = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven at 16x oversampling and
// every rx_done_tick is matched against the queued expected word.
module tb_uart_rx;

  localparam int unsigned BitClks = 64;  // 16 s_ticks, one every 4 clk

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick;
  logic [1:0] tick_cnt = 2'd0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];  // {frame_err, rx_dout}

  uart_rx_if #(.DBIT(8)) bus ();

  uart_rx #(
    .DBIT   (8),
    .SB_TICK(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .s_tick (s_tick),
    .rx     (rx),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
  assign s_tick = (tick_cnt == 2'd3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rx_done_tick) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {31'd0, bus.rx_done_tick}, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("rx_dout", {24'd0, bus.rx_dout}, {24'd0, e[7:0]});
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, e[8]});
      end
    end
  end

  task automatic bits(input int n);
    repeat (n * BitClks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    rx = 1'b0;
    bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      bits(1);
    end
    rx = stop_bit;
    bits(1);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4 * BitClks && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_dout", {24'd0, bus.rx_dout}, 32'd0);
    check("reset_done", {31'd0, bus.rx_done_tick}, 32'd0);
    check("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bits(1);

    // Single frame
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1);
    wait_drain("drain_a5");
    bits(1);

    // Back-to-back, no idle gap
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain("drain_b2b");
    bits(1);

    // 5-tick glitch must be rejected, then a clean frame
    rx = 1'b0;
    repeat (5 * 4) @(negedge clk);
    rx = 1'b1;
    bits(2);
    check("glitch_no_done", exp_q.size(), 32'd0);
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1);
    wait_drain("drain_3c");
    bits(1);

    // Stop bit low: delivered with frame error
    exp_q.push_back({1'b1, 8'h55});
    send_frame(8'h55, 1'b0);
    wait_drain("drain_55");
    bits(2);

    // Break: exactly one frame-error word of zeros
    exp_q.push_back({1'b1, 8'h00});
    rx = 1'b0;
    bits(40);
    rx = 1'b1;
    wait_drain("drain_break");
    bits(2);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1);
    wait_drain("drain_81");
    bits(1);

    // Reset during data bit 4 of 0xC3; nothing may be delivered
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (5 * BitClks + BitClks / 2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_dout", {24'd0, bus.rx_dout}, 32'd0);
        check("rst_done", {31'd0, bus.rx_done_tick}, 32'd0);
        check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
      end
    join
    bits(1);
    reset_n = 1'b1;
    bits(1);
    exp_q.push_back({1'b0, 8'h96});
    send_frame(8'h96, 1'b1);
    wait_drain("drain_96");

    bits(2);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART-FIFO design. It samples the asynchronous `rx` line with the shared 16x baud tick `s_tick`, validates the start bit, and reassembles DBIT data bits LSB-first. It checks the stop bit and presents each received word to the downstream RX FIFO with a one-clock `rx_done_tick` write strobe. It is the line-side counterpart of the transmitter and accepts frames that the transmitter produces with the same DBIT/SB_TICK.

## Interface
- DBIT, 8: number of data bits per frame.
- SB_TICK, 16: stop-bit length in s_ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).

- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- s_tick  input  1  one-clk enable pulse at 16x baud rate.
- rx  input  1  asynchronous serial line, idle high.
- rx_dout  output  DBIT  last received word; valid from the rx_done_tick cycle until the next rx_done_tick.
- rx_done_tick  output  1  one-clk pulse: word complete, acts as FIFO write enable.
- frame_err  output  1  registered; stop-bit sample of the current word was 0. Updated with each rx_done_tick.

## Operation
- `rx` passes through a 2-FF synchronizer (both FFs reset to 1). All logic uses the synchronized value `rx_s`.
- Internal registers:
  - s counter: 4 bits wide, or wide enough for SB_TICK-1.
  - n counter: $clog2(DBIT) bits.
  - b shift register: DBIT bits.
- States:
  - idle: if rx_s==0, go to start and set s=0.
  - start: on s_tick, if s==7 (start-bit midpoint), then if rx_s==0 go to data with s=0 and n=0. Otherwise it is a false start: go to idle. If s!=7, s++.
  - data: on s_tick, if s==15, set s=0 and b={rx_s, b[DBIT-1:1]} (LSB first). If n==DBIT-1, go to stop; otherwise n++. If s!=15, s++.
  - stop: on s_tick, if s==SB_TICK-1, then rx_dout<=b, frame_err<=~rx_s, and pulse rx_done_tick. Then go to idle if rx_s==1, otherwise to wait_hi. If s!=SB_TICK-1, s++.
  - wait_hi: stay until rx_s==1, then go to idle. This blocks a line break (held low) from being decoded as repeated 0x00 frames.
  - Unused encodings go to idle.
- Without s_tick, all counters and the state hold. Only the idle and wait_hi exits ignore s_tick.
- A frame with a framing error is still delivered (rx_done_tick=1, frame_err=1). Downstream decides whether to drop it.

## Timing
- Reset values: state=idle, s=0, n=0, b=0, rx_dout=0, rx_done_tick=0, frame_err=0, sync FFs=1.
- Reset is asynchronous and takes effect mid-frame. The partial word is discarded and no rx_done_tick is issued.
- All outputs are registered, with no combinational path from `rx`.
- Synchronizer latency is 2 clk.
- Start is detected in the first clk after rx_s falls.
- rx_done_tick asserts in the clk after the s_tick on which the stop counter reaches SB_TICK-1. rx_dout and frame_err become valid in that same cycle.
- Total delay from the first synchronized low to the done pulse is 8 + 16*DBIT + SB_TICK s_ticks, plus 1 clk.
- rx_done_tick is exactly one clk wide, regardless of the s_tick spacing.
- A new start bit is accepted in the clk after leaving stop through idle. Back-to-back frames with zero idle time are received without loss.
- A start glitch shorter than 8 s_ticks is rejected. The state returns to idle and there is no output change.

## Test plan
- Send 0xA5 at 16x ticks (s_tick every 4 clk), 1 stop bit -> exactly one rx_done_tick, rx_dout=0xA5, frame_err=0.
- Send 0x00 and 0xFF back-to-back with no idle gap -> two pulses, rx_dout 0x00 then 0xFF, frame_err=0 for both.
- Send a 5-tick low glitch on idle rx -> no rx_done_tick; FSM back in idle, then a following 0x3C is received correctly.
- Send 0x55 with the stop bit forced low -> rx_done_tick with rx_dout=0x55, frame_err=1. The FSM then enters wait_hi.
- Hold rx low for 40 bit times (break) -> exactly one rx_done_tick (rx_dout=0x00, frame_err=1), and no further pulses until rx returns high. A following 0x81 is then received with frame_err=0.
- Assert reset_n low during data bit 4 of 0xC3 -> outputs go to 0 immediately with no done pulse. After release, a fresh 0x96 is received correctly.
